// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : icache_pkg
//  Brief    : Shared types and constants for the direct-mapped instruction
//             cache (FSM encoding, block geometry, instruction width).
//  Revision : 1.0 - initial release
// ============================================================================
package icache_pkg;

  // Block geometry: one line holds a 16-byte memory block
  localparam int BLOCK_BYTES     = 16;
  localparam int BLOCK_BITS      = 128;
  localparam int OFFSET_BITS     = 4;

  // Fetch side
  localparam int INSTR_BITS      = 32;
  localparam int ADDR_BITS       = 32;
  localparam int BLOCK_ADDR_BITS = ADDR_BITS - OFFSET_BITS;

  // Miss-handling controller states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/icache_tag_array.sv
`default_nettype none
// ============================================================================
//  Module   : icache_tag_array
//  Brief    : Valid/tag storage for the instruction cache. Valid bits clear
//             asynchronously on RESET; tags are left unreset. A combinational
//             compare against the lookup tag produces hit.
//  Revision : 1.0 - initial release
// ============================================================================
module icache_tag_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = BLOCK_ADDR_BITS - INDEX_BITS
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [INDEX_BITS-1:0] rd_index,
  input  logic [TAG_BITS-1:0]   rd_tag,
  output logic                  hit,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q [LINES];
  logic [TAG_BITS-1:0] tag_d [LINES];

  // Line fill: mark the selected line valid and record its tag
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (wr_en) begin
      valid_d[wr_index] = 1'b1;
      tag_d[wr_index]   = wr_tag;
    end
  end

  // Valid bits are the only state invalidated by reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag storage needs no reset; it is qualified by the valid bit
  always_ff @(posedge CLK) begin
    tag_q <= tag_d;
  end

  assign hit = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module   : icache
//  Brief    : Direct-mapped read-only instruction cache. Hits return the
//             instruction in the same cycle; misses stall fetch, read one
//             128-bit block from memory, fill the line and then hit.
//  Revision : 1.0 - initial release
// ============================================================================
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 3
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       PC_READ,
  input  logic [ADDR_BITS-1:0]       PC_ADDR,
  output logic [INSTR_BITS-1:0]      INSTR,
  output logic                       CPU_BUSYWAIT,
  output logic                       MEM_READ_EN,
  output logic [BLOCK_ADDR_BITS-1:0] MEM_READ_ADDR,
  input  logic                       MEM_BUSYWAIT,
  input  logic [BLOCK_BITS-1:0]      MEM_READ_DATA
);

  localparam int TAG_BITS = BLOCK_ADDR_BITS - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  state_e                     state_q, state_d;
  logic [BLOCK_ADDR_BITS-1:0] miss_addr_q, miss_addr_d;
  logic [BLOCK_BITS-1:0]      fill_q, fill_d;
  logic [BLOCK_BITS-1:0]      data_q [LINES];
  logic [BLOCK_BITS-1:0]      data_d [LINES];

  // Fetch address split; the byte-within-word bits are not used
  logic [TAG_BITS-1:0]   pc_tag;
  logic [INDEX_BITS-1:0] pc_index;
  logic [1:0]            pc_word;
  logic                  unused_pc_lsbs;
  logic                  hit;
  logic                  line_write;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;

  assign pc_tag         = PC_ADDR[ADDR_BITS-1:OFFSET_BITS+INDEX_BITS];
  assign pc_index       = PC_ADDR[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign pc_word        = PC_ADDR[3:2];
  assign unused_pc_lsbs = ^PC_ADDR[1:0];

  // The fill always targets the latched miss address, not the live PC
  assign line_write = (state_q == ST_UPDATE);
  assign fill_index = miss_addr_q[INDEX_BITS-1:0];
  assign fill_tag   = miss_addr_q[BLOCK_ADDR_BITS-1:INDEX_BITS];

  icache_tag_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_tag_array (
    .CLK      (CLK),
    .RESET    (RESET),
    .rd_index (pc_index),
    .rd_tag   (pc_tag),
    .hit      (hit),
    .wr_en    (line_write),
    .wr_index (fill_index),
    .wr_tag   (fill_tag)
  );

  // Selected word of the addressed line; meaningful only on a hit
  assign INSTR = data_q[pc_index][{pc_word, 5'b0} +: INSTR_BITS];

  // State and miss address register; reset aborts any miss in flight
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Next-state logic, miss address latch and block capture
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    fill_d      = fill_q;
    case (state_q)
      ST_IDLE: begin
        if (PC_READ && !hit) begin
          miss_addr_d = PC_ADDR[ADDR_BITS-1:OFFSET_BITS];
          state_d     = ST_MEM_READ;
        end
      end
      ST_MEM_READ: begin
        if (!MEM_BUSYWAIT) begin
          fill_d  = MEM_READ_DATA;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode: memory request only in MEM_READ, stall on miss or refill
  always_comb begin
    MEM_READ_EN   = (state_q == ST_MEM_READ);
    MEM_READ_ADDR = miss_addr_q;
    CPU_BUSYWAIT  = (state_q != ST_IDLE) || (PC_READ && !hit);
  end

  // Data array write port: refill the missed line during UPDATE
  always_comb begin
    data_d = data_q;
    if (line_write) data_d[fill_index] = fill_q;
  end

  // Fill buffer and data array carry no reset; validity lives in the tag array
  always_ff @(posedge CLK) begin
    fill_q <= fill_d;
    data_q <= data_d;
  end

endmodule
`default_nettype wire

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipeline's fetch stage and the 128-bit-block instruction memory. Fetch hits return a 32-bit instruction combinationally in the same cycle. Misses stall fetch via `CPU_BUSYWAIT`, fetch one 16-byte block over the memory's busywait handshake, fill the line and then serve the hit.

## Interface
- `INDEX_BITS`, 3: set index width (2^INDEX_BITS lines).
- `TAG_BITS`, 28-INDEX_BITS: tag width; derived, not overridden.
- `CLK`  in  1  clock; all state updates on rising edge.
- `RESET`  in  1  reset, asynchronous, active-high.
- `PC_READ`  in  1  fetch request, level-held while stalled.
- `PC_ADDR`  in  32  byte address of instruction.
- `INSTR`  out  32  instruction word; valid when `PC_READ` && !`CPU_BUSYWAIT`.
- `CPU_BUSYWAIT`  out  1  stall to fetch stage.
- `MEM_READ_EN`  out  1  block read request to instruction memory.
- `MEM_READ_ADDR`  out  28  block address (`PC_ADDR[31:4]` of the miss).
- `MEM_BUSYWAIT`  in  1  memory still busy; low with `MEM_READ_EN` high means data is complete.
- `MEM_READ_DATA`  in  128  block; byte k of the block at bits [8k+7:8k].

## Operation
- Address split: tag = `PC_ADDR[31:4+INDEX_BITS]`, index = `PC_ADDR[3+INDEX_BITS:4]`, word = `PC_ADDR[3:2]`; `PC_ADDR[1:0]` ignored.
- Per line: valid bit, tag, 128-bit data. `INSTR` = data word `[32w+31:32w]`, where w is the word field.
- Hit = valid[index] && tag match. The lookup is combinational.
- FSM states:
  - IDLE
    - `PC_READ` && hit → stay; `CPU_BUSYWAIT`=0.
    - `PC_READ` && miss → `CPU_BUSYWAIT`=1 in the same cycle; latch `PC_ADDR[31:4]` into the miss register; go to MEM_READ.
  - MEM_READ
    - `MEM_READ_EN`=1, `MEM_READ_ADDR` = miss register, `CPU_BUSYWAIT`=1.
    - When `MEM_BUSYWAIT`=0 at a rising edge, capture `MEM_READ_DATA` and go to UPDATE.
  - UPDATE
    - `MEM_READ_EN`=0, `CPU_BUSYWAIT`=1.
    - Write data, tag and valid=1 into the line selected by the miss register; go to IDLE.
- Fetch must hold `PC_ADDR` stable while `CPU_BUSYWAIT`=1. The fill always uses the latched miss address.
- No writes, no coherence. A full invalidate happens only on `RESET`.
- `PC_READ`=0 in IDLE: `CPU_BUSYWAIT`=0 and no state change. `INSTR` content in that case is don't-care, but X-free after a fill.

## Timing
- Reset (async, immediate):
  - state=IDLE, all valid=0, miss register=0.
  - `MEM_READ_EN`=0, `CPU_BUSYWAIT`=0, `MEM_READ_ADDR`=0.
  - Tag/data arrays are not reset.
- Reset mid-miss: the request drops in the same cycle. The partially fetched block is discarded and no line is written.
- Hit latency: 0 cycles. The instruction is presented in the same cycle as the request.
- Miss penalty: 1 cycle (IDLE→MEM_READ) + M memory cycles until `MEM_BUSYWAIT` falls + 1 UPDATE cycle. The hit occurs in the following IDLE cycle.
- `MEM_READ_EN` rises on the edge that enters MEM_READ. It falls on the edge that leaves MEM_READ, and is never high in UPDATE.
- `MEM_BUSYWAIT` sampled high while `MEM_READ_EN`=0 is ignored.
- A conflict miss (same index, different tag) overwrites the line in UPDATE. There is no victim write-back.

## Structure
- The shared package holds:
  - FSM state typedef (IDLE/MEM_READ/UPDATE, 2-bit encoding).
  - Block-size constants: 16 bytes, 128 bits, offset width 4.
  - Instruction width 32.
- One sub-module, `icache_tag_array`, is natural: valid/tag storage with async clear, and a combinational compare producing `hit`.
- FSM and data array stay in the top module.

## Test plan
- Cold miss:
  - Stimulus: after reset, `PC_READ`=1, `PC_ADDR`=0x0000_0004.
  - Expected: `CPU_BUSYWAIT`=1 the same cycle; `MEM_READ_EN`=1 with `MEM_READ_ADDR`=0x000_0000.
  - Memory model returns block 0x…_44332211_DDCCBBAA after 16 busy cycles.
  - `INSTR`=0x44332211 with `CPU_BUSYWAIT`=0 two cycles after `MEM_BUSYWAIT` falls.
- Hits in the filled block:
  - Stimulus: `PC_ADDR` 0x0, 0x8, 0xC on consecutive cycles.
  - Expected: correct words each cycle, `CPU_BUSYWAIT`=0, `MEM_READ_EN` never asserted.
- Conflict eviction:
  - Stimulus: fill 0x0000_0000, then 0x0000_0080 (same index 0, different tag), then return to 0x0.
  - Expected: three misses, each issuing a memory read with block addresses 0x0, 0x8, 0x0.
- Distinct indices:
  - Stimulus: fill 0x00, 0x10 … 0x70, then sweep them again.
  - Expected: eight misses, then eight single-cycle hits.
- Reset mid-miss:
  - Stimulus: assert `RESET` during the 5th busy cycle of a miss on 0x20.
  - Expected: `MEM_READ_EN`=0 immediately; a subsequent read of 0x20 misses again; the line was not filled.
- Idle:
  - Stimulus: `PC_READ`=0 with a random `PC_ADDR`.
  - Expected: `CPU_BUSYWAIT`=0 and no memory request for 20 cycles.
